memmu_write_arbiter: RTL and testbench
======================================

Name: memmu_write_arbiter

Overview:
- Sequences and shares the single MemMU write port between two requesters: the SIU point stream (new sensor points) and ExMU rewrites (processed points).
- Drives the MemMU SIU/ExMU select (i_CU_SIU_ExMU) and the per-write ID, and waits for write completion before issuing the next grant.
- Enforces SIU priority with a bounded-starvation guarantee for ExMU.
- Handles frame boundaries and flags memory write timeouts.

Parameters:
- MAX_SIU_BURST, 8: max consecutive SIU grants while an ExMU request is pending; range 1-255.
- TIMEOUT_CYCLES, 1024: cycles to wait for i_MemMU_writeDone before flagging an error; must be >= 2.
- POINTCLOUD_ID, 0: 3-bit ID reported in o_status[7:5].

Ports:
- i_SYSTEM_clk  in  1  system clock, all logic on rising edge.
- i_SYSTEM_rst  in  1  synchronous reset, active-high.
- i_SIU_valid  in  1  SIU write request.
- o_SIU_ready  out  1  SIU request accepted this cycle.
- i_SIU_pointID  in  19  point ID of the SIU request.
- i_SIU_newFrame  in  1  qualifies i_SIU_valid: first point of a new frame.
- i_ExMU_valid  in  1  ExMU rewrite request.
- o_ExMU_ready  out  1  ExMU request accepted this cycle.
- i_ExMU_pointID  in  19  point ID of the ExMU rewrite.
- o_CU_SIU_ExMU  out  1  MemMU source select; 0 = SIU, 1 = ExMU.
- o_MemMU_writeValid  out  1  one-cycle write strobe to MemMU.
- o_MemMU_pointID  out  19  ID of the write being issued.
- i_MemMU_writeDone  in  1  one-cycle completion of the issued write.
- o_frameStart  out  1  one-cycle pulse when a new frame begins.
- o_status  out  32  [0] busy, [1] sticky timeout, [2] frame pending, [4:3] state, [7:5] POINTCLOUD_ID, [15:8] current SIU burst count, [31:16] stats (see Optional Feature).

Behaviour:
- Reset: state IDLE. All outputs 0 except o_status[7:5] = POINTCLOUD_ID. Burst count, timer and sticky bits cleared.
- Reset mid-operation abandons any outstanding write; a late i_MemMU_writeDone is ignored.
- States: IDLE, ISSUE, WAIT_DONE, FRAME_FLUSH.
- Ready outputs are combinational, asserted only in IDLE, and at most one is high per cycle. A transfer happens on valid && ready.
- Grant choice in IDLE:
  - ExMU is granted when i_ExMU_valid && (!i_SIU_valid || burst == MAX_SIU_BURST).
  - Otherwise SIU is granted when i_SIU_valid.
- Burst counter:
  - Increments on each SIU grant made while i_ExMU_valid is high; saturates at MAX_SIU_BURST.
  - Clears on any ExMU grant, and on any SIU grant made while i_ExMU_valid is low.
- Accept cycle → ISSUE: o_CU_SIU_ExMU and o_MemMU_pointID are registered at accept and held stable until the next accept.
- ISSUE: o_MemMU_writeValid = 1 for exactly one cycle (accept + 1), then → WAIT_DONE.
- WAIT_DONE:
  - Timer counts from 0. On i_MemMU_writeDone → IDLE, or → FRAME_FLUSH if a frame is pending.
  - When the timer reaches TIMEOUT_CYCLES-1 without done: set sticky o_status[1] and → IDLE (same frame-pending rule).
  - Done arriving in the same cycle as the timeout counts as success; the error bit is not set.
  - Done outside WAIT_DONE is ignored.
- Frame handling:
  - An accepted SIU request with i_SIU_newFrame = 1 sets frame pending.
  - That write completes normally; then FRAME_FLUSH lasts one cycle: o_frameStart = 1, burst counter cleared, frame pending cleared, → IDLE.
  - No grants are made in FRAME_FLUSH.
- Sticky error clears only on reset.
- Minimum throughput: one write per 3 cycles (accept, ISSUE, done-in-first-WAIT cycle).

Optional Feature:
- Macro MEMMU_ARB_STATS_EN.
- Defined:
  - o_status[23:16] = 8-bit wrapping count of completed SIU writes.
  - o_status[31:24] = 8-bit wrapping count of completed ExMU writes.
  - Both counters clear on reset and on o_frameStart. Timed-out writes are not counted.
- Undefined: o_status[31:16] tied to 0; no counters synthesized.

Test Plan:
- Reset release, both valids low → all outputs 0, o_status = POINTCLOUD_ID<<5; assert i_SIU_valid with ID 0x00010 → o_SIU_ready same cycle, o_MemMU_writeValid next cycle with pointID 0x00010 and select 0; done 2 cycles later → back to IDLE.
- Both valids held high, MAX_SIU_BURST = 8, done returned immediately → grant order is 8 SIU then 1 ExMU, repeating; o_CU_SIU_ExMU = 1 only on every 9th write.
- SIU request with newFrame = 1, done after 5 cycles → o_frameStart pulses exactly 1 cycle after done; no ready asserted that cycle; burst counter reads 0.
- TIMEOUT_CYCLES = 16, done withheld → at cycle 16 of WAIT_DONE o_status[1] = 1 and state IDLE; a later stray done is ignored; next request served normally with the error bit still set.
- Reset asserted during WAIT_DONE, done arriving 1 cycle after reset release → outputs 0, no write counted, state IDLE.
- With MEMMU_ARB_STATS_EN: 3 SIU + 2 ExMU completed writes → o_status[23:16] = 3, [31:24] = 2; after a newFrame flush both read 0.

Source files
------------

// File: rtl/memmu_write_arbiter.sv
// memmu_write_arbiter
//
// Shares the single MemMU write port between the SIU point stream and ExMU
// rewrites. SIU has priority, but while an ExMU request is waiting the SIU
// may only win MAX_SIU_BURST grants in a row before ExMU is served. Each
// grant issues one write strobe, then the arbiter waits for the write to
// complete (or time out) before it grants again. A write that starts a new
// frame is followed by a one-cycle frame flush.
//
// Optional build macro: MEMMU_ARB_STATS_EN
//   defined   -> o_status[31:16] carries completed-write counters
//   undefined -> o_status[31:16] reads 0 and no counters are built
//
// Parameters
//   MAX_SIU_BURST   consecutive SIU grants allowed while ExMU waits (1-255)
//   TIMEOUT_CYCLES  WAIT_DONE cycles before a write is declared lost (>= 2)
//   POINTCLOUD_ID   3-bit ID reported in o_status[7:5]
//
// Ports
//   i_SYSTEM_clk        system clock, rising edge
//   i_SYSTEM_rst        synchronous reset, active high
//   i_SIU_valid         SIU write request
//   o_SIU_ready         SIU request accepted this cycle (combinational)
//   i_SIU_pointID       point ID of the SIU request
//   i_SIU_newFrame      SIU request is the first point of a new frame
//   i_ExMU_valid        ExMU rewrite request
//   o_ExMU_ready        ExMU request accepted this cycle (combinational)
//   i_ExMU_pointID      point ID of the ExMU rewrite
//   o_CU_SIU_ExMU       MemMU source select, 0 = SIU, 1 = ExMU
//   o_MemMU_writeValid  one-cycle write strobe
//   o_MemMU_pointID     ID of the write being issued
//   i_MemMU_writeDone   one-cycle completion of the issued write
//   o_frameStart        one-cycle pulse when a new frame begins
//   o_status            [0] busy, [1] sticky timeout, [2] frame pending,
//                       [4:3] state, [7:5] POINTCLOUD_ID,
//                       [15:8] SIU burst count, [31:16] stats
//
// State table
//   state       | meaning
//   IDLE        | ready for a grant; the only state where ready may be high
//   ISSUE       | write strobe to MemMU, timer loaded
//   WAIT_DONE   | waiting for writeDone or timer terminal count
//   FRAME_FLUSH | one-cycle frame boundary: frameStart, burst/pending cleared

module memmu_write_arbiter #(
  parameter int unsigned MAX_SIU_BURST  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [2:0]  POINTCLOUD_ID  = 3'd0
) (
  input  logic        i_SYSTEM_clk,
  input  logic        i_SYSTEM_rst,
  input  logic        i_SIU_valid,
  output logic        o_SIU_ready,
  input  logic [18:0] i_SIU_pointID,
  input  logic        i_SIU_newFrame,
  input  logic        i_ExMU_valid,
  output logic        o_ExMU_ready,
  input  logic [18:0] i_ExMU_pointID,
  output logic        o_CU_SIU_ExMU,
  output logic        o_MemMU_writeValid,
  output logic [18:0] o_MemMU_pointID,
  input  logic        i_MemMU_writeDone,
  output logic        o_frameStart,
  output logic [31:0] o_status
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    WAIT_DONE   = 2'd2,
    FRAME_FLUSH = 2'd3
  } state_t;

  localparam int unsigned  TW          = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    BURST_MAX  = 8'(MAX_SIU_BURST);

  state_t        state;
  logic [7:0]    burst;
  logic [TW-1:0] timer;
  logic          frame_pending;
  logic          timeout_err;
  logic          sel;
  logic [18:0]   point_id;
  logic          wr_valid;
  logic          frame_start;
  logic [15:0]   stats;

  logic burst_full;
  logic grant_exmu;
  logic grant_siu;

  // ExMU wins when SIU is idle or SIU has used up its burst allowance.
  assign burst_full = (burst == BURST_MAX);
  assign grant_exmu = (state == IDLE) && i_ExMU_valid && (!i_SIU_valid || burst_full);
  assign grant_siu  = (state == IDLE) && i_SIU_valid && !grant_exmu;

  assign o_SIU_ready  = grant_siu;
  assign o_ExMU_ready = grant_exmu;

  always_ff @(posedge i_SYSTEM_clk) begin
    if (i_SYSTEM_rst) begin
      state         <= IDLE;
      burst         <= '0;
      timer         <= '0;
      frame_pending <= 1'b0;
      timeout_err   <= 1'b0;
      sel           <= 1'b0;
      point_id      <= '0;
      wr_valid      <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      wr_valid    <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_exmu) begin
            sel      <= 1'b1;
            point_id <= i_ExMU_pointID;
            burst    <= '0;
            wr_valid <= 1'b1;
            state    <= ISSUE;
          end else if (grant_siu) begin
            sel      <= 1'b0;
            point_id <= i_SIU_pointID;
            wr_valid <= 1'b1;
            state    <= ISSUE;
            // The burst only counts against a waiting ExMU requester.
            if (i_ExMU_valid) begin
              if (!burst_full) burst <= burst + 8'd1;
            end else begin
              burst <= '0;
            end
            if (i_SIU_newFrame) frame_pending <= 1'b1;
          end
        end
        ISSUE: begin
          timer <= TIMER_LOAD;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // Done wins over a simultaneous terminal count.
          if (i_MemMU_writeDone || (timer == '0)) begin
            if (!i_MemMU_writeDone) timeout_err <= 1'b1;
            if (frame_pending) begin
              frame_pending <= 1'b0;
              burst         <= '0;
              frame_start   <= 1'b1;
              state         <= FRAME_FLUSH;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        FRAME_FLUSH: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEMMU_ARB_STATS_EN
  logic [7:0] siu_wr_cnt;
  logic [7:0] exmu_wr_cnt;

  // Only writes that really completed are counted; timeouts are not.
  always_ff @(posedge i_SYSTEM_clk) begin
    if (i_SYSTEM_rst || frame_start) begin
      siu_wr_cnt  <= '0;
      exmu_wr_cnt <= '0;
    end else if ((state == WAIT_DONE) && i_MemMU_writeDone) begin
      if (sel) exmu_wr_cnt <= exmu_wr_cnt + 8'd1;
      else     siu_wr_cnt  <= siu_wr_cnt + 8'd1;
    end
  end

  assign stats = {exmu_wr_cnt, siu_wr_cnt};
`else
  assign stats = '0;
`endif

  assign o_CU_SIU_ExMU      = sel;
  assign o_MemMU_pointID    = point_id;
  assign o_MemMU_writeValid = wr_valid;
  assign o_frameStart       = frame_start;

  assign o_status = {stats, burst, POINTCLOUD_ID, state, frame_pending,
                     timeout_err, (state != IDLE)};

endmodule

// File: tb/tb_memmu_write_arbiter.sv
module tb_memmu_write_arbiter;

  localparam int unsigned MAXB  = 8;
  localparam int unsigned TMO   = 16;
  localparam logic [2:0]  PCID  = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        siu_valid = 1'b0;
  logic        siu_ready;
  logic [18:0] siu_id = '0;
  logic        siu_nf = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [18:0] ex_id = '0;
  logic        sel;
  logic        wv;
  logic [18:0] wid;
  logic        done = 1'b0;
  logic        fstart;
  logic [31:0] status;

  int total = 0;
  int bad   = 0;

  logic [19:0] exp_q[$];
  logic [7:0]  m_burst = '0;
  logic [7:0]  m_siu = '0;
  logic [7:0]  m_ex = '0;
  logic        m_last_sel = 1'b0;

  always #5 clk = ~clk;

  memmu_write_arbiter #(
    .MAX_SIU_BURST (MAXB),
    .TIMEOUT_CYCLES(TMO),
    .POINTCLOUD_ID (PCID)
  ) dut (
    .i_SYSTEM_clk      (clk),
    .i_SYSTEM_rst      (rst),
    .i_SIU_valid       (siu_valid),
    .o_SIU_ready       (siu_ready),
    .i_SIU_pointID     (siu_id),
    .i_SIU_newFrame    (siu_nf),
    .i_ExMU_valid      (ex_valid),
    .o_ExMU_ready      (ex_ready),
    .i_ExMU_pointID    (ex_id),
    .o_CU_SIU_ExMU     (sel),
    .o_MemMU_writeValid(wv),
    .o_MemMU_pointID   (wid),
    .i_MemMU_writeDone (done),
    .o_frameStart      (fstart),
    .o_status          (status)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_stats();
`ifdef MEMMU_ARB_STATS_EN
    return {m_ex, m_siu};
`else
    return 16'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE, check the grant against the model, accept it.
  task automatic request(input logic sv, input logic [18:0] sid, input logic nf,
                         input logic ev, input logic [18:0] eid);
    logic e_ex;
    logic e_siu;
    siu_valid = sv; siu_id = sid; siu_nf = nf;
    ex_valid  = ev; ex_id  = eid;
    #1;
    e_ex  = ev && (!sv || (m_burst == 8'(MAXB)));
    e_siu = sv && !e_ex;
    chk("siu_ready", 32'(siu_ready), 32'(e_siu));
    chk("exmu_ready", 32'(ex_ready), 32'(e_ex));
    if (e_ex) begin
      exp_q.push_back({1'b1, eid});
      m_burst    = '0;
      m_last_sel = 1'b1;
    end else if (e_siu) begin
      exp_q.push_back({1'b0, sid});
      if (ev) begin
        if (m_burst != 8'(MAXB)) m_burst = m_burst + 8'd1;
      end else begin
        m_burst = '0;
      end
      m_last_sel = 1'b0;
    end
    tick();
    siu_valid = 1'b0; ex_valid = 1'b0; siu_nf = 1'b0;
  endtask

  // Called in the ISSUE cycle; returns done in WAIT_DONE cycle (delay+1).
  task automatic serve(input int delay);
    tick();
    repeat (delay) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    if (m_last_sel) m_ex = m_ex + 8'd1;
    else            m_siu = m_siu + 8'd1;
  endtask

  // Scoreboard: every write strobe must match the oldest expected grant.
  always @(negedge clk) begin
    if (!rst && wv) begin
      logic [19:0] e;
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_sel", 32'(sel), 32'(e[19]));
        chk("write_id", 32'(wid), 32'(e[18:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle outputs
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_status", status, 32'(PCID) << 5);
    chk("rst_siu_ready", 32'(siu_ready), 0);
    chk("rst_exmu_ready", 32'(ex_ready), 0);
    chk("rst_wv", 32'(wv), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_id", 32'(wid), 0);
    chk("rst_fstart", 32'(fstart), 0);
    tick();

    // Single SIU write, done in second WAIT cycle
    request(1'b1, 19'h00010, 1'b0, 1'b0, '0);
    chk("issue_wv", 32'(wv), 1);
    chk("issue_state", 32'(status[4:3]), 1);
    chk("issue_busy", 32'(status[0]), 1);
    serve(1);
    chk("single_idle", 32'(status[4:3]), 0);
    chk("single_busy", 32'(status[0]), 0);

    // Both requesters saturated: 8 SIU then 1 ExMU, at full throughput
    for (int i = 0; i < 18; i++) begin
      request(1'b1, 19'(20'h100 + i), 1'b0, 1'b1, 19'(20'h4000 + i));
      serve(0);
      chk("burst_cnt", 32'(status[15:8]), 32'(m_burst));
    end

    // New frame with ExMU waiting, done after 5 cycles
    request(1'b1, 19'h00123, 1'b1, 1'b1, 19'h0777);
    chk("frame_pending", 32'(status[2]), 1);
    chk("frame_burst_issue", 32'(status[15:8]), 32'(m_burst));
    serve(4);
    chk("fstart_pulse", 32'(fstart), 1);
    chk("flush_state", 32'(status[4:3]), 3);
    siu_valid = 1'b1; ex_valid = 1'b1;
    #1;
    chk("flush_siu_ready", 32'(siu_ready), 0);
    chk("flush_exmu_ready", 32'(ex_ready), 0);
    tick();
    siu_valid = 1'b0; ex_valid = 1'b0;
    m_burst = '0; m_siu = '0; m_ex = '0;
    #1;
    chk("fstart_one_cycle", 32'(fstart), 0);
    chk("frame_pending_clr", 32'(status[2]), 0);
    chk("frame_burst_clr", 32'(status[15:8]), 0);
    chk("frame_stats_clr", 32'(status[31:16]), 32'(exp_stats()));

    // Timeout with done withheld
    request(1'b1, 19'h00055, 1'b0, 1'b0, '0);
    tick();
    repeat (TMO - 1) tick();
    chk("tmo_wait16_state", 32'(status[4:3]), 2);
    chk("tmo_wait16_err", 32'(status[1]), 0);
    tick();
    chk("tmo_err_set", 32'(status[1]), 1);
    chk("tmo_idle", 32'(status[4:3]), 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("stray_done_idle", 32'(status[4:3]), 0);
    request(1'b0, '0, 1'b0, 1'b1, 19'h007AB);
    serve(0);
    chk("tmo_err_sticky", 32'(status[1]), 1);
    chk("tmo_stats", 32'(status[31:16]), 32'(exp_stats()));

    // Reset during WAIT_DONE, late done after release
    request(1'b1, 19'h002AA, 1'b0, 1'b0, '0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_burst = '0; m_siu = '0; m_ex = '0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("rstmid_status", status, 32'(PCID) << 5);
    chk("rstmid_wv", 32'(wv), 0);
    chk("rstmid_sel", 32'(sel), 0);
    chk("rstmid_id", 32'(wid), 0);
    chk("rstmid_fstart", 32'(fstart), 0);

    // Completed-write statistics
    for (int i = 0; i < 3; i++) begin
      request(1'b1, 19'(20'h200 + i), 1'b0, 1'b0, '0);
      serve(0);
    end
    for (int i = 0; i < 2; i++) begin
      request(1'b0, '0, 1'b0, 1'b1, 19'(20'h300 + i));
      serve(i);
    end
    chk("stats_counts", 32'(status[31:16]), 32'(exp_stats()));
    request(1'b1, 19'h00001, 1'b1, 1'b0, '0);
    serve(0);
    chk("stats_fstart", 32'(fstart), 1);
    tick();
    m_siu = '0; m_ex = '0;
    chk("stats_after_flush", 32'(status[31:16]), 32'(exp_stats()));
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
